addsub_seq_ctrl: RTL and testbench

Multi-cycle sequencer that runs WIDTH-bit add/subtract operations through a single shared 4-bit universal add/subtract slice, one nibble per clock, LSB nibble first. The block latches the operands and the operation on a start request and steps the nibble index. It chains the carry between nibbles and drives the slice's carry-in to select the mode: 0 for add, 1 for subtract with b inverted. It assembles the result and flags, then reports completion with a one-cycle done pulse. It sits between a simple command source and the 4-bit adder datapath, so that wider arithmetic reuses the existing nibble slice instead of instantiating a full-width adder.

---
 rtl/addsub_seq_ctrl_pkg.sv | 12 +
 rtl/addsub_seq_ctrl_nibble_addsub.sv | 24 ++
 rtl/addsub_seq_ctrl.sv | 111 +++++++++++
 tb/tb_addsub_seq_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/addsub_seq_ctrl_pkg.sv
// Shared encodings for the nibble-serial add/subtract sequencer.
package addsub_seq_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int   NIBBLE = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/addsub_seq_ctrl_nibble_addsub.sv
// Combinational 4-bit add slice; also exposes the carry into bit 3 for
// signed-overflow detection on the top nibble.
module nibble_addsub
    import addsub_seq_ctrl_pkg::*;
(
    input  logic [NIBBLE-1:0] a_i,
    input  logic [NIBBLE-1:0] b_i,
    input  logic              cin_i,
    output logic [NIBBLE-1:0] sum_o,
    output logic              cout_o,
    output logic              c3_o
);
    logic [NIBBLE:0]   full;
    logic [NIBBLE-1:0] low;

    always_comb begin
        full   = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE{1'b0}}, cin_i};
        low    = {1'b0, a_i[NIBBLE-2:0]} + {1'b0, b_i[NIBBLE-2:0]}
               + {{(NIBBLE-1){1'b0}}, cin_i};
        sum_o  = full[NIBBLE-1:0];
        cout_o = full[NIBBLE];
        c3_o   = low[NIBBLE-1];
    end
endmodule

// File: rtl/addsub_seq_ctrl.sv
// WIDTH-bit add/subtract sequenced through one shared 4-bit slice,
// LSB nibble first, with a one-cycle done pulse.
module addsub_seq_ctrl
    import addsub_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int NUM_NIB = WIDTH / NIBBLE;
    localparam int IW      = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_NIB - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             op_q, op_d, cy_q, cy_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [NIBBLE-1:0] sl_a, sl_b, sl_sum;
    logic              sl_cout, sl_c3;

    // Subtract is a + ~b + 1: the inversion lives here, the +1 in the carry.
    assign sl_a = a_q[int'(idx_q)*NIBBLE +: NIBBLE];
    assign sl_b = b_q[int'(idx_q)*NIBBLE +: NIBBLE] ^ {NIBBLE{op_q}};

    nibble_addsub u_slice (
        .a_i    (sl_a),
        .b_i    (sl_b),
        .cin_i  (cy_q),
        .sum_o  (sl_sum),
        .cout_o (sl_cout),
        .c3_o   (sl_c3)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            cy_q    <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cy_q    <= cy_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cy_d    = cy_q;
        idx_d   = idx_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cy_d    = op;
                    idx_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[int'(idx_q)*NIBBLE +: NIBBLE] = sl_sum;
                cy_d  = sl_cout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = sl_cout;
                    ovf_d   = sl_c3 ^ sl_cout;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = res_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed bench for addsub_seq_ctrl: arithmetic reference model checked
// every cycle, plus literal expectations per transaction.
module tb_addsub_seq_ctrl;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;

    addsub_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the two's-complement definitions.
    task automatic ref_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0] full;
        if (o) full = {1'b0, x} + {1'b0, ~y} + 1;
        else   full = {1'b0, x} + {1'b0, y};
        r = full[W-1:0];
        c = full[W];
        if (o) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        else   v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endtask

    bit           m_init = 0, m_known = 0, m_done = 0;
    int           m_cnt = 0;
    logic [W-1:0] m_res = '0, p_res;
    logic         m_cout = 0, m_ovf = 0, p_cout, p_ovf;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init = 1; m_cnt = 0; m_done = 0;
            m_res = '0; m_cout = 0; m_ovf = 0; m_known = 1;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1; m_res = p_res; m_cout = p_cout; m_ovf = p_ovf; m_known = 1;
            end
        end else if (start) begin
            ref_op(op, a, b, p_res, p_cout, p_ovf);
            m_cnt = NIB;
            m_known = 0;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_busy", {31'b0, busy}, {31'b0, m_cnt > 0});
            chk("model_done", {31'b0, done}, {31'b0, m_done});
            chk("model_cout", {31'b0, cout}, {31'b0, m_cout});
            chk("model_ovf",  {31'b0, ovf},  {31'b0, m_ovf});
            if (m_known) chk("model_result", {16'b0, result}, {16'b0, m_res});
        end
    end

    // Launch one operation and check latency, busy length and the literal result.
    task automatic run_op(input string nm, input logic o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] er,
                          input logic ec, input logic ev, input bit hold);
        int lat, bcnt;
        start = 1; op = o; a = x; b = y;
        @(posedge clk); #1;
        if (hold) begin op = 1'b0; a = 16'hAAAA; b = 16'h1111; end
        else start = 0;
        lat = 0; bcnt = 0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        start = 0;
        if (lat >= 20) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_latency"}, lat, NIB);
        chk({nm, "_busycyc"}, bcnt, NIB);
        chk({nm, "_result"}, {16'b0, result}, {16'b0, er});
        chk({nm, "_cout"}, {31'b0, cout}, {31'b0, ec});
        chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, ev});
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, {31'b0, done}, 0);
        chk({nm, "_hold"}, {16'b0, result}, {16'b0, er});
    endtask

    initial begin
        int dcnt;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_result", {16'b0, result}, 0);
        chk("rst_flags", {30'b0, cout, ovf}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        run_op("add_basic", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 0, 0, 0);
        run_op("add_sovf",  1'b0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0);
        run_op("add_wrap",  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0);
        run_op("sub_borrow",1'b1, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, 0);
        run_op("sub_equal", 1'b1, 16'h4321, 16'h4321, 16'h0000, 1, 0, 0);

        // Start held high through the whole run must not queue a second op.
        run_op("busy_rej",  1'b1, 16'h0010, 16'h0001, 16'h000F, 1, 0, 1);
        dcnt = 0;
        repeat (4) begin @(posedge clk); #1; if (done) dcnt++; end
        chk("busy_rej_no_extra_done", dcnt, 0);
        run_op("idle_start",1'b0, 16'hAAAA, 16'h1111, 16'hBBBB, 0, 0, 0);

        run_op("sub_sovf",  1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0);

        // Reset lands on the edge that would write nibble 2.
        start = 1; op = 0; a = 16'h1234; b = 16'h0FFF;
        @(posedge clk); #1; start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_result", {16'b0, result}, 0);
        chk("midrst_flags", {30'b0, cout, ovf}, 0);
        rst_n = 1;
        dcnt = 0;
        repeat (6) begin @(posedge clk); #1; if (done) dcnt++; end
        chk("midrst_no_done", dcnt, 0);
        run_op("post_rst",  1'b0, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
